ascon_serial_io_ctrl: RTL and testbench
=======================================

Name: ascon_serial_io_ctrl

Overview:
- Sits between a parallel host interface and the bit-serial Ascon encryption core.
- Accepts key/nonce/AD/PT words over a valid/ready handshake, then shifts them MSB-first into the core's serial share inputs, with the mask share bits drawn from an internal LFSR.
- Pulses encryption start and waits for the core's ready.
- Deserialises the ciphertext and tag streams and presents them as parallel words over a second valid/ready handshake.

Parameters:
- K, 128, key width in bits.
- Y, 96, plaintext/ciphertext width in bits.
- L, 40, associated-data width in bits.
- START_CYCLES, 3, number of cycles encryption_startxSI is held high (must be ≥1).
- GAP_CYCLES, 2, idle cycles between encryption_readyxSO and the first capture.
- SEED, 64'hACE1_0F0F_1234_5678, LFSR reset value (must be nonzero).
- MAX, derived = max(K, Y, L), serial transfer length in cycles.

Ports:
- clk  in  1  clock, all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  host request valid.
- in_ready  out  1  high only in IDLE.
- key_in  in  K  key.
- nonce_in  in  128  nonce.
- ad_in  in  L  associated data.
- pt_in  in  Y  plaintext.
- keyxSI, noncexSI, associated_dataxSI, plain_textxSI  out  5 each  serial shares; bit0 = data bit, bits[4:1] = mask bits.
- r_64xSI  out  14  fresh randomness.
- r_128xSI  out  3  fresh randomness.
- r_ptxSI  out  3  fresh randomness.
- encryption_startxSI  out  1  core start.
- encryption_readyxSO  in  1  core done level.
- cipher_textxSO  in  1  serial ciphertext bit.
- tagxSO  in  1  serial tag bit.
- out_valid  out  1  result valid.
- out_ready  in  1  host accepts result.
- ct_out  out  Y  ciphertext.
- tag_out  out  128  tag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - State to IDLE; counter to 0; LFSR to SEED.
  - All serial outputs, randomness outputs, encryption_startxSI and out_valid are 0.
  - ct_out and tag_out are 0; in_ready=1; busy=0.
- Reset mid-operation aborts immediately. No partial result is ever flagged valid.
- LFSR: 64-bit Galois, taps x^64+x^63+x^61+x^60+1, advances every cycle in LOAD only.
- State IDLE: on in_valid&&in_ready, register all four input words, clear the counter i, go to LOAD.
- State LOAD: one cycle per i = 0..MAX-1, all outputs registered.
  - keyxSI[0] = key[K-1-i], noncexSI[0] = nonce[127-i], associated_dataxSI[0] = ad[L-1-i], plain_textxSI[0] = pt[Y-1-i].
  - Any index below 0 (word shorter than MAX) drives 0.
  - {r_128xSI, r_ptxSI, r_64xSI, keyxSI[4:1], associated_dataxSI[4:1], plain_textxSI[4:1], noncexSI[4:1]} = lfsr[35:0].
  - After the cycle with i = MAX-1, go to START.
  - Serial and randomness outputs return to 0 outside LOAD.
- State START: encryption_startxSI = 1 for exactly START_CYCLES cycles, then go to WAIT.
- State WAIT: encryption_startxSI = 0. Wait for encryption_readyxSO sampled 1, then go to GAP. No timeout.
- State GAP: count GAP_CYCLES cycles, then go to READ with i = 0.
- State READ: MAX cycles, LSB-first capture on each edge.
  - ct_out[i] <= cipher_textxSO for i < Y.
  - tag_out[i] <= tagxSO for i < 128.
  - Bits at i ≥ width are ignored.
  - After i = MAX-1, go to DONE.
- State DONE: out_valid = 1; ct_out and tag_out held stable. On out_valid&&out_ready, out_valid drops next cycle and the state goes to IDLE.
- in_valid outside IDLE is ignored (in_ready=0). encryption_readyxSO outside WAIT is ignored.
- Total latency from accept to out_valid: MAX + START_CYCLES + (ready delay) + GAP_CYCLES + MAX + 1 cycles.
- in_ready returns 1 on the cycle after the DONE handshake. There is no back-to-back overlap.
- Counter width: clog2(MAX)+1. Wrap never occurs because the counter is cleared on each state entry.

Test Plan:
- Reset, then accept KEY=128'h5362006eff0b33bc8bb9950abdb242fc, NONCE=128'h1ccfafbc6dc738283ca9fe21ce0fccaa, AD=40'h4153434f4e, PT=96'h48656c6c6f20576f726c6421. Required: noncexSI[0] sequence equals NONCE MSB-first over 128 cycles; AD bit0 is 0 for i ≥ 40; PT bit0 is 0 for i ≥ 96.
- Required: encryption_startxSI high exactly 3 cycles immediately after cycle 128 of LOAD; randomness outputs match a reference LFSR model seeded with SEED.
- Stub core raises ready 50 cycles after start and drives cipher_textxSO = i[0], tagxSO = ~i[0]. Required: ct_out = 96'h...AAAA, tag_out = 128'h5555...5555, out_valid at the predicted cycle.
- Hold out_ready=0 for 10 cycles in DONE. Required: out_valid and data stable. Pulse out_ready: IDLE and in_ready=1 next cycle.
- Assert in_valid during LOAD/WAIT and encryption_readyxSO during LOAD. Required: no state change and no second accept.
- Drop rst mid-READ. Required: all outputs zero immediately (async); after release in_ready=1, LFSR equals SEED, out_valid never asserted.

Source files
------------

// File: rtl/ascon_serial_io_ctrl_if.sv
// Host-side bundle for ascon_serial_io_ctrl: request words in, result words out.
// master = host driving requests, slave = the controller.
interface ascon_serial_io_ctrl_if #(
    parameter int K = 128,
    parameter int Y = 96,
    parameter int L = 40
);
    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   key_in;
    logic [127:0]   nonce_in;
    logic [L-1:0]   ad_in;
    logic [Y-1:0]   pt_in;
    logic           out_valid;
    logic           out_ready;
    logic [Y-1:0]   ct_out;
    logic [127:0]   tag_out;
    logic           busy;

    modport master (
        output in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
        input  in_ready, out_valid, ct_out, tag_out, busy
    );

    modport slave (
        input  in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
        output in_ready, out_valid, ct_out, tag_out, busy
    );
endinterface

// File: rtl/ascon_serial_io_ctrl.sv
// Parallel-to-serial front end for the bit-serial Ascon core.
// Ports: clk/rst (async active-low), host bundle, serial shares, randomness, core start/ready/ct/tag.
module ascon_serial_io_ctrl #(
    parameter int          K            = 128,
    parameter int          Y            = 96,
    parameter int          L            = 40,
    parameter int          START_CYCLES = 3,
    parameter int          GAP_CYCLES   = 2,
    parameter logic [63:0] SEED         = 64'hACE1_0F0F_1234_5678
) (
    input  logic                  clk,
    input  logic                  rst,
    ascon_serial_io_ctrl_if.slave host,
    output logic [4:0]            keyxSI,
    output logic [4:0]            noncexSI,
    output logic [4:0]            associated_dataxSI,
    output logic [4:0]            plain_textxSI,
    output logic [13:0]           r_64xSI,
    output logic [2:0]            r_128xSI,
    output logic [2:0]            r_ptxSI,
    output logic                  encryption_startxSI,
    input  logic                  encryption_readyxSO,
    input  logic                  cipher_textxSO,
    input  logic                  tagxSO
);
    localparam int MAX = (K >= Y) ? ((K >= L) ? K : L) : ((Y >= L) ? Y : L);
    localparam int CW  = $clog2(MAX) + 1;
    localparam int YW  = $clog2(Y);

    localparam logic [CW-1:0] C_LOAD  = CW'(MAX - 1);
    localparam logic [CW-1:0] C_START = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYCLES - 1);

    // Galois right-shift mask for x^64+x^63+x^61+x^60+1
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_lfsr;
    logic [K-1:0]  r_key;
    logic [127:0]  r_nonce;
    logic [L-1:0]  r_ad;
    logic [Y-1:0]  r_pt;
    logic [4:0]    r_key_si;
    logic [4:0]    r_nonce_si;
    logic [4:0]    r_ad_si;
    logic [4:0]    r_pt_si;
    logic [13:0]   r_r64;
    logic [2:0]    r_r128;
    logic [2:0]    r_rpt;
    logic          r_start;
    logic [Y-1:0]  r_ct;
    logic [127:0]  r_tag;
    logic [63:0]   w_lfsr_next;

    assign w_lfsr_next = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? TAPS : 64'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lfsr     <= SEED;
            r_key      <= '0;
            r_nonce    <= '0;
            r_ad       <= '0;
            r_pt       <= '0;
            r_key_si   <= '0;
            r_nonce_si <= '0;
            r_ad_si    <= '0;
            r_pt_si    <= '0;
            r_r64      <= '0;
            r_r128     <= '0;
            r_rpt      <= '0;
            r_start    <= 1'b0;
            r_ct       <= '0;
            r_tag      <= '0;
        end else begin
            r_key_si   <= '0;
            r_nonce_si <= '0;
            r_ad_si    <= '0;
            r_pt_si    <= '0;
            r_r64      <= '0;
            r_r128     <= '0;
            r_rpt      <= '0;
            r_start    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host.in_valid) begin
                        r_key   <= host.key_in;
                        r_nonce <= host.nonce_in;
                        r_ad    <= host.ad_in;
                        r_pt    <= host.pt_in;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Words shift out MSB-first; shorter words run dry into zeros.
                    r_key_si   <= {r_lfsr[15:12], r_key[K-1]};
                    r_ad_si    <= {r_lfsr[11:8], r_ad[L-1]};
                    r_pt_si    <= {r_lfsr[7:4], r_pt[Y-1]};
                    r_nonce_si <= {r_lfsr[3:0], r_nonce[127]};
                    r_r64      <= r_lfsr[29:16];
                    r_rpt      <= r_lfsr[32:30];
                    r_r128     <= r_lfsr[35:33];
                    r_key      <= r_key << 1;
                    r_nonce    <= r_nonce << 1;
                    r_ad       <= r_ad << 1;
                    r_pt       <= r_pt << 1;
                    r_lfsr     <= w_lfsr_next;
                    if (r_cnt == C_LOAD) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_START: begin
                    r_start <= 1'b1;
                    if (r_cnt == C_START) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (encryption_readyxSO) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == C_GAP) begin
                        r_cnt   <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_READ: begin
                    if (r_cnt < CW'(Y))
                        r_ct[r_cnt[YW-1:0]] <= cipher_textxSO;
                    if (r_cnt < CW'(128))
                        r_tag[r_cnt[6:0]] <= tagxSO;
                    if (r_cnt == C_LOAD) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (host.out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host.in_ready       = (r_state == S_IDLE);
    assign host.busy           = (r_state != S_IDLE);
    assign host.out_valid      = (r_state == S_DONE);
    assign host.ct_out         = r_ct;
    assign host.tag_out        = r_tag;
    assign keyxSI              = r_key_si;
    assign noncexSI            = r_nonce_si;
    assign associated_dataxSI  = r_ad_si;
    assign plain_textxSI       = r_pt_si;
    assign r_64xSI             = r_r64;
    assign r_128xSI            = r_r128;
    assign r_ptxSI             = r_rpt;
    assign encryption_startxSI = r_start;
endmodule

// File: tb/tb_ascon_serial_io_ctrl.sv
// Directed bench for ascon_serial_io_ctrl with a stub serial core.
// Cycle n = n-th rising edge after the accepting edge; outputs sampled 1 ns after edges.
module tb_ascon_serial_io_ctrl;
    localparam logic [127:0] KEY   = 128'h5362006eff0b33bc8bb9950abdb242fc;
    localparam logic [127:0] NONCE = 128'h1ccfafbc6dc738283ca9fe21ce0fccaa;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [95:0]  PT    = 96'h48656c6c6f20576f726c6421;
    localparam logic [63:0]  SEED  = 64'hACE1_0F0F_1234_5678;
    localparam logic [95:0]  CT_EXP  = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] TAG_EXP = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    // Serial bits after edges 1..128, start after 129..131, ready driven after 179
    // and sampled at 180 (49 WAIT edges), GAP 181..182, READ 183..310.
    localparam int START_N = 129;
    localparam int READY_N = 179;
    localparam int READ0_N = 183;
    localparam int VALID_N = 310;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  keyxSI, noncexSI, associated_dataxSI, plain_textxSI;
    logic [13:0] r_64xSI;
    logic [2:0]  r_128xSI, r_ptxSI;
    logic        encryption_startxSI;
    logic        encryption_readyxSO = 1'b0;
    logic        cipher_textxSO = 1'b0;
    logic        tagxSO = 1'b0;

    int assertions = 0;
    int failures   = 0;

    ascon_serial_io_ctrl_if hif ();

    ascon_serial_io_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .host                (hif),
        .keyxSI              (keyxSI),
        .noncexSI            (noncexSI),
        .associated_dataxSI  (associated_dataxSI),
        .plain_textxSI       (plain_textxSI),
        .r_64xSI             (r_64xSI),
        .r_128xSI            (r_128xSI),
        .r_ptxSI             (r_ptxSI),
        .encryption_startxSI (encryption_startxSI),
        .encryption_readyxSO (encryption_readyxSO),
        .cipher_textxSO      (cipher_textxSO),
        .tagxSO              (tagxSO)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [65:0] serial_bus();
        return {keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
                r_64xSI, r_128xSI, r_ptxSI, encryption_startxSI};
    endfunction

    task automatic stub_drive(input int n);
        int j;
        j = n + 1 - READ0_N;
        if (j >= 0 && j < 128) begin
            cipher_textxSO = j[0];
            tagxSO         = ~j[0];
        end else begin
            cipher_textxSO = 1'b0;
            tagxSO         = 1'b0;
        end
    endtask

    task automatic accept();
        hif.key_in   = KEY;
        hif.nonce_in = NONCE;
        hif.ad_in    = AD;
        hif.pt_in    = PT;
        hif.in_valid = 1'b1;
        @(posedge clk); #1;
        hif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (serial_bus() !== 66'h0) begin
            failures++;
            $display("FAIL reset_serial: got %0h expected 0", serial_bus());
        end
        assertions++;
        if ({hif.in_ready, hif.busy, hif.out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 100",
                     {hif.in_ready, hif.busy, hif.out_valid});
        end
        assertions++;
        if (hif.ct_out !== 96'h0 || hif.tag_out !== 128'h0) begin
            failures++;
            $display("FAIL reset_data: got %0h/%0h expected 0/0", hif.ct_out, hif.tag_out);
        end
        assertions++;
        if (dut.r_lfsr !== SEED) begin
            failures++;
            $display("FAIL reset_lfsr: got %0h expected %0h", dut.r_lfsr, SEED);
        end
        rst = 1'b1;
    endtask

    task automatic test_encrypt();
        logic [127:0] key_seq, nonce_seq, ad_seq, pt_seq;
        logic [63:0]  m;
        logic [35:0]  rnd;
        int start_first, start_cnt, valid_n;
        key_seq = '0; nonce_seq = '0; ad_seq = '0; pt_seq = '0;
        m = SEED;
        start_first = -1; start_cnt = 0; valid_n = -1;
        accept();
        assertions++;
        if (hif.in_ready !== 1'b0 || hif.busy !== 1'b1) begin
            failures++;
            $display("FAIL accept_flags: got ready=%b busy=%b expected 0/1",
                     hif.in_ready, hif.busy);
        end
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n <= 128) begin
                key_seq[128-n]   = keyxSI[0];
                nonce_seq[128-n] = noncexSI[0];
                ad_seq[128-n]    = associated_dataxSI[0];
                pt_seq[128-n]    = plain_textxSI[0];
                rnd = {r_128xSI, r_ptxSI, r_64xSI, keyxSI[4:1],
                       associated_dataxSI[4:1], plain_textxSI[4:1], noncexSI[4:1]};
                assertions++;
                if (rnd !== m[35:0]) begin
                    failures++;
                    $display("FAIL rand_cycle%0d: got %0h expected %0h", n, rnd, m[35:0]);
                end
                m = lfsr_step(m);
            end
            if (n == 129) begin
                assertions++;
                if (serial_bus() !== 66'h1) begin
                    failures++;
                    $display("FAIL serial_idle_after_load: got %0h expected 1", serial_bus());
                end
            end
            if (n == 100 || n == 170) begin
                assertions++;
                if (hif.in_ready !== 1'b0 || hif.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL ignore_in_valid_n%0d: got ready=%b busy=%b expected 0/1",
                             n, hif.in_ready, hif.busy);
                end
            end
            if (encryption_startxSI === 1'b1) begin
                if (start_cnt == 0) start_first = n;
                start_cnt++;
            end
            if (hif.out_valid === 1'b1) begin
                valid_n = n;
                break;
            end
            // Spurious request with other data through LOAD and WAIT
            hif.in_valid = (n >= 5 && n < 250);
            hif.key_in   = ~KEY;
            hif.nonce_in = ~NONCE;
            hif.ad_in    = ~AD;
            hif.pt_in    = ~PT;
            // Spurious ready during LOAD, real ready from cycle READY_N
            encryption_readyxSO = (n >= 10 && n < 60) || (n >= READY_N);
            stub_drive(n);
        end
        hif.in_valid = 1'b0;
        encryption_readyxSO = 1'b0;
        assertions++;
        if (valid_n != VALID_N) begin
            failures++;
            $display("FAIL out_valid_cycle: got %0d expected %0d", valid_n, VALID_N);
        end
        assertions++;
        if (nonce_seq !== NONCE) begin
            failures++;
            $display("FAIL nonce_serial: got %0h expected %0h", nonce_seq, NONCE);
        end
        assertions++;
        if (key_seq !== KEY) begin
            failures++;
            $display("FAIL key_serial: got %0h expected %0h", key_seq, KEY);
        end
        assertions++;
        if (ad_seq !== {AD, 88'h0}) begin
            failures++;
            $display("FAIL ad_serial: got %0h expected %0h", ad_seq, {AD, 88'h0});
        end
        assertions++;
        if (pt_seq !== {PT, 32'h0}) begin
            failures++;
            $display("FAIL pt_serial: got %0h expected %0h", pt_seq, {PT, 32'h0});
        end
        assertions++;
        if (start_first != START_N || start_cnt != 3) begin
            failures++;
            $display("FAIL start_pulse: got first=%0d len=%0d expected %0d/3",
                     start_first, start_cnt, START_N);
        end
        assertions++;
        if (hif.ct_out !== CT_EXP) begin
            failures++;
            $display("FAIL ct_out: got %0h expected %0h", hif.ct_out, CT_EXP);
        end
        assertions++;
        if (hif.tag_out !== TAG_EXP) begin
            failures++;
            $display("FAIL tag_out: got %0h expected %0h", hif.tag_out, TAG_EXP);
        end
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            assertions++;
            if (hif.out_valid !== 1'b1 || hif.ct_out !== CT_EXP || hif.tag_out !== TAG_EXP) begin
                failures++;
                $display("FAIL done_hold%0d: got v=%b ct=%0h tag=%0h expected 1/%0h/%0h",
                         k, hif.out_valid, hif.ct_out, hif.tag_out, CT_EXP, TAG_EXP);
            end
        end
        hif.out_ready = 1'b1;
        @(posedge clk); #1;
        hif.out_ready = 1'b0;
        assertions++;
        if ({hif.out_valid, hif.in_ready, hif.busy} !== 3'b010) begin
            failures++;
            $display("FAIL done_handshake: got %b expected 010",
                     {hif.out_valid, hif.in_ready, hif.busy});
        end
    endtask

    task automatic test_reset_mid_read();
        logic seen_valid;
        seen_valid = 1'b0;
        accept();
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            encryption_readyxSO = (n >= 150);
            stub_drive(n);
        end
        assertions++;
        if (hif.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_busy: got %b expected 1", hif.busy);
        end
        rst = 1'b0;
        #1;
        assertions++;
        if (serial_bus() !== 66'h0 || hif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: got %0h v=%b expected 0/0",
                     serial_bus(), hif.out_valid);
        end
        assertions++;
        if (hif.ct_out !== 96'h0 || hif.tag_out !== 128'h0) begin
            failures++;
            $display("FAIL abort_data: got %0h/%0h expected 0/0", hif.ct_out, hif.tag_out);
        end
        assertions++;
        if (hif.in_ready !== 1'b1 || hif.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags: got ready=%b busy=%b expected 1/0",
                     hif.in_ready, hif.busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        encryption_readyxSO = 1'b0;
        cipher_textxSO = 1'b0;
        tagxSO = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (hif.out_valid === 1'b1) seen_valid = 1'b1;
        end
        assertions++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_partial_valid: got %b expected 0", seen_valid);
        end
        assertions++;
        if (dut.r_lfsr !== SEED || hif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: got lfsr=%0h ready=%b expected %0h/1",
                     dut.r_lfsr, hif.in_ready, SEED);
        end
    endtask

    initial begin
        hif.in_valid  = 1'b0;
        hif.out_ready = 1'b0;
        hif.key_in    = '0;
        hif.nonce_in  = '0;
        hif.ad_in     = '0;
        hif.pt_in     = '0;
        test_reset();
        @(posedge clk); #1;
        test_encrypt();
        test_done_hold();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
